// File: rtl/bch_gf_pkg.sv
// GF(2^13) constants and elaboration-time helpers shared by the BCH decoder.
// Polynomial basis, primitive polynomial x^13 + x^4 + x^3 + x + 1.
package bch_gf_pkg;

  localparam int M = 13;
  localparam int T = 32;
  localparam int N_LEN = 4199;
  localparam int START_EXP = 3992;
  localparam int GF_ORDER = (1 << M) - 1;
  localparam logic [M:0] PRIM_POLY = 14'h201B;

  typedef logic [M-1:0] gf_t;
  typedef logic [M-1:0][M-1:0] gf_mat_t;

  typedef enum logic {
    IDLE,
    RUN
  } chien_state_t;

  function automatic gf_t gf_mul_alpha(input gf_t a);
    return {a[M-2:0], 1'b0} ^ ({M{a[M-1]}} & PRIM_POLY[M-1:0]);
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    gf_t x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_mul_alpha(x);
    end
    return p;
  endfunction

  // Square-and-multiply keeps elaboration cheap for large exponents.
  function automatic gf_t gf_alpha_pow(input int e);
    gf_t r;
    gf_t b;
    int k;
    k = e % GF_ORDER;
    if (k < 0) k = k + GF_ORDER;
    r = gf_t'(1);
    b = gf_t'(2);
    for (int i = 0; i < M; i++) begin
      if (((k >> i) & 1) != 0) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  // Entry i is the image of basis bit i under multiplication by alpha^e.
  function automatic gf_mat_t gf_mul_const_matrix(input int e);
    gf_mat_t mat;
    gf_t k;
    k = gf_alpha_pow(e);
    for (int i = 0; i < M; i++) begin
      mat[i] = gf_mul(k, gf_t'(1) << i);
    end
    return mat;
  endfunction

endpackage

// File: rtl/bch_gf_const_mul.sv
// Constant GF(2^13) multiplier: c = a * alpha^EXP.
// Pure XOR network; the matrix is fixed at elaboration.
module bch_gf_const_mul
  import bch_gf_pkg::*;
#(
  parameter int EXP = 0
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] c
);

  localparam gf_mat_t MAT = gf_mul_const_matrix(EXP);

  always_comb begin
    c = '0;
    for (int i = 0; i < M; i++) begin
      if (a[i]) c = c ^ MAT[i];
    end
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates sigma at alpha^(e0+i) for every codeword
// position and streams per-position error flags plus a final root count.
module bch_chien_search
  import bch_gf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sigma_valid,
  output logic                 sigma_ready,
  input  logic [(T+1)*M-1:0]   sigma,
  input  logic [5:0]           sigma_deg,
  output logic                 err_valid,
  input  logic                 err_ready,
  output logic                 err_flag,
  output logic [12:0]          err_pos,
  output logic                 err_last,
  output logic [5:0]           err_count,
  output logic                 dec_fail
);

  chien_state_t state;
  chien_state_t state_d;

  gf_t r      [T+1];
  gf_t r_step [T+1];
  gf_t r_load [T+1];

  logic [12:0] pos;
  logic [5:0]  count;
  logic [5:0]  count_d;
  logic [5:0]  deg;
  gf_t         eval;
  logic        flag;
  logic        last;
  logic        load;
  logic        adv;

  for (genvar j = 0; j <= T; j++) begin : g_term
    localparam int PE = (j * START_EXP) % GF_ORDER;

    bch_gf_const_mul #(.EXP(j)) u_step (
      .a (r[j]),
      .c (r_step[j])
    );

    bch_gf_const_mul #(.EXP(PE)) u_load (
      .a (sigma[j*M +: M]),
      .c (r_load[j])
    );
  end

  always_comb begin
    eval = '0;
    for (int j = 0; j <= T; j++) begin
      eval = eval ^ r[j];
    end
  end

  assign flag = (eval == '0);
  assign last = (pos == 13'(N_LEN - 1));

  // Root count saturates so an all-zero sigma cannot wrap it.
  assign count_d = (flag && count != 6'(T)) ? count + 6'd1 : count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    sigma_ready = 1'b0;
    load        = 1'b0;
    adv         = 1'b0;
    unique case (state)
      IDLE: begin
        sigma_ready = 1'b1;
        if (sigma_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        adv = !err_valid || err_ready;
        if (adv && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= '0;
      count     <= '0;
      deg       <= '0;
      err_valid <= 1'b0;
      err_flag  <= 1'b0;
      err_pos   <= '0;
      err_last  <= 1'b0;
      err_count <= '0;
      dec_fail  <= 1'b0;
      for (int j = 0; j <= T; j++) r[j] <= '0;
    end else begin
      if (load) begin
        for (int j = 0; j <= T; j++) r[j] <= r_load[j];
        deg   <= sigma_deg;
        pos   <= '0;
        count <= '0;
      end else if (adv) begin
        for (int j = 0; j <= T; j++) r[j] <= r_step[j];
        pos   <= pos + 13'd1;
        count <= count_d;
      end

      // Output register: capture on advance, otherwise drain.
      if (adv) begin
        err_valid <= 1'b1;
        err_flag  <= flag;
        err_pos   <= pos;
        err_last  <= last;
        err_count <= count_d;
        dec_fail  <= (count_d != deg);
      end else if (err_ready) begin
        err_valid <= 1'b0;
      end
    end
  end

endmodule
